// File: rtl/iob_cache_ctrl_regs_if.sv
// rtl/iob_cache_ctrl_regs_if.sv - control-register access bus for the cache controller
//   req   : access request, one cycle per access (master -> slave)
//   addr  : control word address, sampled with req (master -> slave)
//   rdata : read data, valid only while ack is high (slave -> master)
//   ack   : one-cycle completion pulse, one cycle after req (slave -> master)
interface iob_cache_ctrl_regs_if #(
    parameter int DATA_W      = 32,
    parameter int CTRL_ADDR_W = 4
);
    logic                   req;
    logic [CTRL_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]      rdata;
    logic                   ack;

    modport master (output req, output addr, input rdata, input ack);
    modport slave  (input req, input addr, output rdata, output ack);
endinterface

// File: rtl/iob_cache_ctrl_regs.sv
// rtl/iob_cache_ctrl_regs.sv - cache control/status registers with hit/miss counters
//   clk_i          : clock
//   reset          : asynchronous active-high reset
//   bus            : slave side of the control access bus (req/addr/rdata/ack)
//   wtb_empty_i    : write-through buffer empty status
//   wtb_full_i     : write-through buffer full status
//   read_hit_i, read_miss_i, write_hit_i, write_miss_i : single-cycle event pulses
//   invalidate_o   : cache invalidate pulse, coincident with the ack of an INVALIDATE access
// Build option: define IOB_CACHE_CTRL_CNT_EN to build the six event counters and RST_CNT.
// Without it, counter addresses read 0 and the event inputs are ignored.
module iob_cache_ctrl_regs #(
    parameter int DATA_W      = 32,
    parameter int CTRL_ADDR_W = 4
) (
    input  logic                        clk_i,
    input  logic                        reset,
    iob_cache_ctrl_regs_if.slave        bus,
    input  logic                        wtb_empty_i,
    input  logic                        wtb_full_i,
    input  logic                        read_hit_i,
    input  logic                        read_miss_i,
    input  logic                        write_hit_i,
    input  logic                        write_miss_i,
    output logic                        invalidate_o
);
    localparam logic [CTRL_ADDR_W-1:0] A_WTB_EMPTY  = CTRL_ADDR_W'(0);
    localparam logic [CTRL_ADDR_W-1:0] A_WTB_FULL   = CTRL_ADDR_W'(1);
    localparam logic [CTRL_ADDR_W-1:0] A_INVALIDATE = CTRL_ADDR_W'(9);

    logic [DATA_W-1:0] rd_data;

`ifdef IOB_CACHE_CTRL_CNT_EN
    localparam logic [CTRL_ADDR_W-1:0] A_RW_HIT     = CTRL_ADDR_W'(2);
    localparam logic [CTRL_ADDR_W-1:0] A_RW_MISS    = CTRL_ADDR_W'(3);
    localparam logic [CTRL_ADDR_W-1:0] A_READ_HIT   = CTRL_ADDR_W'(4);
    localparam logic [CTRL_ADDR_W-1:0] A_READ_MISS  = CTRL_ADDR_W'(5);
    localparam logic [CTRL_ADDR_W-1:0] A_WRITE_HIT  = CTRL_ADDR_W'(6);
    localparam logic [CTRL_ADDR_W-1:0] A_WRITE_MISS = CTRL_ADDR_W'(7);
    localparam logic [CTRL_ADDR_W-1:0] A_RST_CNT    = CTRL_ADDR_W'(8);

    logic [DATA_W-1:0] rw_hit_cnt, rw_miss_cnt;
    logic [DATA_W-1:0] rd_hit_cnt, rd_miss_cnt, wr_hit_cnt, wr_miss_cnt;
    logic              rst_cnt;

    // Saturating add of 0..2; the carry out of the widened sum flags overflow.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] cnt,
                                                  input logic [1:0]        inc);
        logic [DATA_W:0] sum;
        sum = {1'b0, cnt} + {{(DATA_W-1){1'b0}}, inc};
        return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    endfunction

    assign rst_cnt = bus.req && (bus.addr == A_RST_CNT);

    // A clear wins over same-cycle events, which are dropped.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            rw_hit_cnt  <= '0;
            rw_miss_cnt <= '0;
            rd_hit_cnt  <= '0;
            rd_miss_cnt <= '0;
            wr_hit_cnt  <= '0;
            wr_miss_cnt <= '0;
        end else if (rst_cnt) begin
            rw_hit_cnt  <= '0;
            rw_miss_cnt <= '0;
            rd_hit_cnt  <= '0;
            rd_miss_cnt <= '0;
            wr_hit_cnt  <= '0;
            wr_miss_cnt <= '0;
        end else begin
            rw_hit_cnt  <= sat_add(rw_hit_cnt,  {1'b0, read_hit_i}  + {1'b0, write_hit_i});
            rw_miss_cnt <= sat_add(rw_miss_cnt, {1'b0, read_miss_i} + {1'b0, write_miss_i});
            rd_hit_cnt  <= sat_add(rd_hit_cnt,  {1'b0, read_hit_i});
            rd_miss_cnt <= sat_add(rd_miss_cnt, {1'b0, read_miss_i});
            wr_hit_cnt  <= sat_add(wr_hit_cnt,  {1'b0, write_hit_i});
            wr_miss_cnt <= sat_add(wr_miss_cnt, {1'b0, write_miss_i});
        end
    end
`else
    wire unused_events = read_hit_i ^ read_miss_i ^ write_hit_i ^ write_miss_i;
`endif

    // Read mux sees counter values before this cycle's events are added.
    always_comb begin
        rd_data = '0;
        case (bus.addr)
            A_WTB_EMPTY:  rd_data = {{(DATA_W-1){1'b0}}, wtb_empty_i};
            A_WTB_FULL:   rd_data = {{(DATA_W-1){1'b0}}, wtb_full_i};
`ifdef IOB_CACHE_CTRL_CNT_EN
            A_RW_HIT:     rd_data = rw_hit_cnt;
            A_RW_MISS:    rd_data = rw_miss_cnt;
            A_READ_HIT:   rd_data = rd_hit_cnt;
            A_READ_MISS:  rd_data = rd_miss_cnt;
            A_WRITE_HIT:  rd_data = wr_hit_cnt;
            A_WRITE_MISS: rd_data = wr_miss_cnt;
`endif
            default:      rd_data = '0;
        endcase
    end

    // Fixed one-cycle response; rdata is forced to 0 when no ack is due.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            bus.ack      <= 1'b0;
            bus.rdata    <= '0;
            invalidate_o <= 1'b0;
        end else begin
            bus.ack      <= bus.req;
            bus.rdata    <= bus.req ? rd_data : '0;
            invalidate_o <= bus.req && (bus.addr == A_INVALIDATE);
        end
    end
endmodule

// File: tb/tb_iob_cache_ctrl_regs.sv
// tb/tb_iob_cache_ctrl_regs.sv - randomized and directed checks of iob_cache_ctrl_regs
module tb_iob_cache_ctrl_regs;
    localparam int     DW   = 8;
    localparam int     AW   = 4;
    localparam longint MAXV = (longint'(1) << DW) - 1;
`ifdef IOB_CACHE_CTRL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic reset = 1'b1;
    logic wtb_empty_i = 1'b0, wtb_full_i = 1'b0;
    logic read_hit_i = 1'b0, read_miss_i = 1'b0, write_hit_i = 1'b0, write_miss_i = 1'b0;
    logic invalidate_o;

    int checks = 0;
    int errors = 0;

    iob_cache_ctrl_regs_if #(.DATA_W(DW), .CTRL_ADDR_W(AW)) bus ();

    iob_cache_ctrl_regs #(.DATA_W(DW), .CTRL_ADDR_W(AW)) dut (
        .clk_i        (clk_i),
        .reset        (reset),
        .bus          (bus),
        .wtb_empty_i  (wtb_empty_i),
        .wtb_full_i   (wtb_full_i),
        .read_hit_i   (read_hit_i),
        .read_miss_i  (read_miss_i),
        .write_hit_i  (write_hit_i),
        .write_miss_i (write_miss_i),
        .invalidate_o (invalidate_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: unbounded event totals since the last clear; a counter read is
    // the total clipped to the maximum value.
    longint n_rh = 0, n_rm = 0, n_wh = 0, n_wm = 0;
    logic          exp_ack = 1'b0, exp_inv = 1'b0;
    logic [DW-1:0] exp_rdata = '0;

    function automatic longint clip(input longint t);
        return (t > MAXV) ? MAXV : t;
    endfunction

    function automatic longint model_read(input int a);
        case (a)
            0: return longint'(wtb_empty_i);
            1: return longint'(wtb_full_i);
            2: return CNT_EN ? clip(n_rh + n_wh) : 0;
            3: return CNT_EN ? clip(n_rm + n_wm) : 0;
            4: return CNT_EN ? clip(n_rh) : 0;
            5: return CNT_EN ? clip(n_rm) : 0;
            6: return CNT_EN ? clip(n_wh) : 0;
            7: return CNT_EN ? clip(n_wm) : 0;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk_i or posedge reset) begin
        if (reset) begin
            exp_ack   <= 1'b0;
            exp_inv   <= 1'b0;
            exp_rdata <= '0;
            n_rh <= 0; n_rm <= 0; n_wh <= 0; n_wm <= 0;
        end else begin
            exp_ack   <= bus.req;
            exp_inv   <= bus.req && (bus.addr == 4'd9);
            exp_rdata <= bus.req ? DW'(model_read(int'(bus.addr))) : '0;
            if (bus.req && bus.addr == 4'd8) begin
                n_rh <= 0; n_rm <= 0; n_wh <= 0; n_wm <= 0;
            end else begin
                n_rh <= n_rh + longint'(read_hit_i);
                n_rm <= n_rm + longint'(read_miss_i);
                n_wh <= n_wh + longint'(write_hit_i);
                n_wm <= n_wm + longint'(write_miss_i);
            end
        end
    end

    always @(negedge clk_i) begin
        check("ack", 32'(bus.ack), 32'(exp_ack));
        check("invalidate_o", 32'(invalidate_o), 32'(exp_inv));
        if (exp_ack) check("rdata", 32'(bus.rdata), 32'(exp_rdata));
    end

    function automatic logic [31:0] ec(input logic [31:0] v);
        return CNT_EN ? v : 32'd0;
    endfunction

    // Called at posedge+1; returns the response sampled at the following posedge+1.
    task automatic access(input logic [AW-1:0] a, output logic ack_s,
                          output logic [31:0] rd_s, output logic inv_s);
        bus.req  = 1'b1;
        bus.addr = a;
        @(posedge clk_i); #1;
        bus.req  = 1'b0;
        ack_s = bus.ack;
        rd_s  = 32'(bus.rdata);
        inv_s = invalidate_o;
    endtask

    task automatic pulses(input logic rh, input logic rm, input logic wh, input logic wm,
                          input int n);
        read_hit_i = rh; read_miss_i = rm; write_hit_i = wh; write_miss_i = wm;
        repeat (n) @(posedge clk_i);
        #1;
        read_hit_i = 1'b0; read_miss_i = 1'b0; write_hit_i = 1'b0; write_miss_i = 1'b0;
    endtask

    initial begin
        logic        a_s, i_s;
        logic [31:0] r_s;
        int          r;
        bus.req  = 1'b0;
        bus.addr = '0;

        // A request while reset is held is dropped.
        repeat (2) @(posedge clk_i);
        #1;
        bus.req = 1'b1; bus.addr = 4'd9;
        @(posedge clk_i); #1;
        check("reset_ack", 32'(bus.ack), 32'd0);
        check("reset_inv", 32'(invalidate_o), 32'd0);
        check("reset_rdata", 32'(bus.rdata), 32'd0);
        bus.req = 1'b0;
        reset   = 1'b0;

        // Status reads.
        wtb_empty_i = 1'b1;
        access(4'd0, a_s, r_s, i_s);
        check("empty_ack", 32'(a_s), 32'd1);
        check("empty_rdata", r_s, 32'd1);
        check("empty_inv", 32'(i_s), 32'd0);
        wtb_empty_i = 1'b0; wtb_full_i = 1'b1;
        access(4'd1, a_s, r_s, i_s);
        check("full_rdata", r_s, 32'd1);
        wtb_full_i = 1'b0;

        // Hit counting, including a double pulse into RW_HIT.
        pulses(1'b1, 1'b0, 1'b0, 1'b0, 3);
        pulses(1'b1, 1'b0, 1'b1, 1'b0, 1);
        access(4'd2, a_s, r_s, i_s);
        check("rw_hit", r_s, ec(32'd5));
        access(4'd4, a_s, r_s, i_s);
        check("read_hit", r_s, ec(32'd4));

        // A read excludes an event in its own cycle.
        read_hit_i = 1'b1;
        access(4'd4, a_s, r_s, i_s);
        read_hit_i = 1'b0;
        check("read_hit_same_cycle", r_s, ec(32'd4));
        access(4'd4, a_s, r_s, i_s);
        check("read_hit_after", r_s, ec(32'd5));

        // Asynchronous reset clears pending outputs and counters without a clock edge.
        bus.req = 1'b1; bus.addr = 4'd9;
        @(posedge clk_i); #1;
        bus.req = 1'b0;
        check("pre_reset_inv", 32'(invalidate_o), 32'd1);
        reset = 1'b1;
        #1;
        check("async_ack", 32'(bus.ack), 32'd0);
        check("async_inv", 32'(invalidate_o), 32'd0);
        @(posedge clk_i); #1;
        reset = 1'b0;
        access(4'd4, a_s, r_s, i_s);
        check("cnt_after_reset", r_s, 32'd0);

        // Clear discards a same-cycle event.
        pulses(1'b0, 1'b0, 1'b0, 1'b1, 2);
        access(4'd7, a_s, r_s, i_s);
        check("write_miss", r_s, ec(32'd2));
        write_miss_i = 1'b1;
        access(4'd8, a_s, r_s, i_s);
        write_miss_i = 1'b0;
        check("rst_cnt_ack", 32'(a_s), 32'd1);
        check("rst_cnt_rdata", r_s, 32'd0);
        access(4'd7, a_s, r_s, i_s);
        check("write_miss_cleared", r_s, 32'd0);

        // Saturation.
        pulses(1'b0, 1'b1, 1'b0, 1'b0, int'(MAXV) - 1);
        access(4'd5, a_s, r_s, i_s);
        check("read_miss_max_m1", r_s, ec(32'(MAXV - 1)));
        pulses(1'b0, 1'b1, 1'b0, 1'b0, 3);
        access(4'd5, a_s, r_s, i_s);
        check("read_miss_sat", r_s, ec(32'(MAXV)));
        access(4'd3, a_s, r_s, i_s);
        check("rw_miss_sat", r_s, ec(32'(MAXV)));

        // Invalidate followed back-to-back by an unmapped access.
        access(4'd9, a_s, r_s, i_s);
        check("inv_ack", 32'(a_s), 32'd1);
        check("inv_pulse", 32'(i_s), 32'd1);
        check("inv_rdata", r_s, 32'd0);
        access(4'd12, a_s, r_s, i_s);
        check("unmapped_ack", 32'(a_s), 32'd1);
        check("unmapped_inv", 32'(i_s), 32'd0);
        check("unmapped_rdata", r_s, 32'd0);
        @(posedge clk_i); #1;
        check("idle_ack", 32'(bus.ack), 32'd0);

        // Hits after a clear.
        access(4'd8, a_s, r_s, i_s);
        pulses(1'b1, 1'b0, 1'b1, 1'b0, 10);
        access(4'd2, a_s, r_s, i_s);
        check("hits_ack", 32'(a_s), 32'd1);
        check("hits_rw", r_s, ec(32'd20));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.req = ($urandom_range(0, 1) == 1);
            r = int'($urandom_range(0, 255));
            if (r == 0) bus.addr = 4'd8;
            else begin
                bus.addr = AW'($urandom_range(0, 15));
                if (bus.addr == 4'd8) bus.addr = 4'd9;
            end
            read_hit_i   = ($urandom_range(0, 3) != 0);
            read_miss_i  = ($urandom_range(0, 3) != 0);
            write_hit_i  = ($urandom_range(0, 3) != 0);
            write_miss_i = ($urandom_range(0, 3) != 0);
            wtb_empty_i  = 1'($urandom_range(0, 1));
            wtb_full_i   = 1'($urandom_range(0, 1));
            @(posedge clk_i); #1;
        end
        bus.req = 1'b0;
        read_hit_i = 1'b0; read_miss_i = 1'b0; write_hit_i = 1'b0; write_miss_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/iob_cache_ctrl_regs.md
IOB_CACHE_CTRL_REGS -- requirements
Module: iob_cache_ctrl_regs

Interface
- REQ-001 Parameter DATA_W, default 32: width of counters and read data.
- REQ-002 Parameter CTRL_ADDR_W, default 4: width of the control word address.
- REQ-003 clk_i  input  1: the single clock.
- REQ-004 reset  input  1: asynchronous reset, active-high.
- REQ-005 req  input  1: control access request, one cycle per access.
- REQ-006 addr  input  CTRL_ADDR_W: control word address, sampled with req.
- REQ-007 rdata  output  DATA_W: read data, valid only while ack is high.
- REQ-008 ack  output  1: access completion, one-cycle pulse.
- REQ-009 wtb_empty_i  input  1: write-through buffer empty status.
- REQ-010 wtb_full_i  input  1: write-through buffer full status.
- REQ-011 read_hit_i, read_miss_i, write_hit_i, write_miss_i  input  1 each: single-cycle event pulses from the cache controller.
- REQ-012 invalidate_o  output  1: cache invalidate pulse.

Function
- REQ-013 Word map: 0 WTB_EMPTY; 1 WTB_FULL; 2 RW_HIT; 3 RW_MISS; 4 READ_HIT; 5 READ_MISS; 6 WRITE_HIT; 7 WRITE_MISS; 8 RST_CNT; 9 INVALIDATE; all other addresses are unmapped.
- REQ-014 Latency: ack SHALL go high exactly one cycle after req, with rdata registered in the same edge; back-to-back req on consecutive cycles SHALL each be acked.
- REQ-015 Reads of 0/1 SHALL return the status bit sampled in the req cycle, zero-extended to DATA_W.
- REQ-016 Reads of 2-7 SHALL return the counter value as of the req cycle, excluding that cycle's events.
- REQ-017 Reads of 8, 9 and unmapped addresses SHALL return 0 and still be acked.
- REQ-018 Access to 8 SHALL clear all counters at the edge ending the req cycle; events in that same cycle SHALL be discarded.
- REQ-019 Access to 9 SHALL assert invalidate_o for exactly one cycle, coincident with ack.
- REQ-020 READ_HIT, READ_MISS, WRITE_HIT and WRITE_MISS SHALL each increment by 1 per cycle in which their pulse is high.
- REQ-021 RW_HIT SHALL add read_hit_i+write_hit_i, and RW_MISS read_miss_i+write_miss_i, so that simultaneous pulses add 2.
- REQ-022 All counters SHALL saturate at 2^DATA_W-1 and never wrap.
- REQ-023 Counter update, clear and read SHALL be independent of pending acks; req never stalls.

Reset
- REQ-024 On reset, ack, rdata, invalidate_o and all counters SHALL be 0 immediately, without waiting for a clock edge.
- REQ-025 A req in the cycle reset is asserted SHALL be dropped: no ack and no invalidate_o.

Configuration
- REQ-026 Macro IOB_CACHE_CTRL_CNT_EN defined: the six counters and RST_CNT are implemented per REQ-016/018/020-022.
- REQ-027 IOB_CACHE_CTRL_CNT_EN undefined: no counter registers are built; reads of 2-8 return 0 with normal ack; event inputs are ignored.

Verification
- REQ-028 Reset, then req addr=0 with wtb_empty_i=1 -> ack high next cycle, rdata=1, invalidate_o=0.
- REQ-029 3 read_hit_i pulses, then 1 cycle with read_hit_i and write_hit_i both high, then read addr 2 and addr 4 -> rdata=5, then rdata=4.
- REQ-030 Preload READ_MISS to 2^DATA_W-2, apply 3 read_miss_i pulses, then read addr 5 -> rdata=0xFFFFFFFF (DATA_W=32).
- REQ-031 req addr=8 with write_miss_i=1 in the same cycle, then read addr 7 -> rdata=0, and ack for the addr 8 access has rdata=0.
- REQ-032 req addr=9, then req addr=12 on the next cycle -> invalidate_o high exactly one cycle; two consecutive acks; second rdata=0.
- REQ-033 Build without IOB_CACHE_CTRL_CNT_EN and apply 10 hit pulses, then read addr 2 -> rdata=0 and ack asserted.
